copy_verifier: RTL and testbench
================================

// Module: copy_verifier
// PURPOSE
//  Post-copy checker downstream of the copy datapath. When the copy reports done, it
//  re-reads the block word by word from the source and destination memories (their
//  spare read ports) and compares each pair. Reports pass/fail, mismatch count and
//  first failing offset/data, exposing parity-error-injection escapes.
// PARAMETERS
//  ADDR_W  12  memory address width; addresses wrap modulo 2**ADDR_W
//  WIDTH   16  memory word width
// PORTS
//  clk             in   1          rising-edge clock
//  rst             in   1          asynchronous, active-low reset
//  start           in   1          one-cycle pulse: begin verify (tie to copy done rise)
//  src_start       in   ADDR_W     first source address, sampled on accepted start
//  dst_start       in   ADDR_W     first destination address, sampled on accepted start
//  length          in   ADDR_W     words to check, sampled on accepted start; 0 = none
//  src_addr        out  ADDR_W     source memory read address (registered)
//  src_dout        in   WIDTH      source read data, valid 1 cycle after src_addr
//  dst_addr        out  ADDR_W     destination memory read address (registered)
//  dst_dout        in   WIDTH      destination read data, valid 1 cycle after dst_addr
//  busy            out  1          verify in progress
//  result_valid    out  1          results below are final
//  pass            out  1          1 = every compared word matched
//  err_count       out  ADDR_W+1   mismatching words, saturates at all-ones
//  first_err_off   out  ADDR_W     offset (0-based) of first mismatch
//  first_err_src   out  WIDTH      source word at first mismatch
//  first_err_dst   out  WIDTH      destination word at first mismatch
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; every output 0; internal counters 0.
//  - FSM IDLE -> READ -> DRAIN -> DONE. start is accepted in IDLE or DONE only;
//    ignored in READ/DRAIN. Accepted start in DONE clears results, restarts.
//  - Accepted start at cycle 0, length L>0: cycles 1..L state READ, src_addr =
//    src_start+k, dst_addr = dst_start+k for k=0..L-1 (each ADDR_W-bit, wraps).
//    Cycles 2..L+1 compare src_dout vs dst_dout for offset k-1 (1-cycle read latency,
//    tracked by a registered compare-valid bit). Cycle L+1 state DRAIN (last
//    compare). Cycle L+2 state DONE: busy=0, result_valid=1. busy=1 cycles 1..L+1.
//  - L=0: IDLE -> DONE directly at cycle 1; pass=1, err_count=0, busy never high.
//  - On accepted start: result_valid, err_count, first_err_* cleared, pass set to 1
//    the following cycle.
//  - Mismatch: err_count+1 (saturating at 2**(ADDR_W+1)-1); pass cleared; first_err_*
//    captured only on first mismatch of the run, held thereafter.
//  - In DONE all results hold until next accepted start or reset. Addresses hold
//    last value outside READ.
//  - Reset asserted mid-run aborts immediately; no partial result is reported.
// TESTING
//  1 Clean block: mems identical, src_start=0x010, dst_start=0x800, L=8, start ->
//    addrs 0x010..0x017 / 0x800..0x807, busy 9 cycles, result_valid at cycle 10,
//    pass=1, err_count=0.
//  2 Single fault: dst[0x803] ^= 0x8000, same run -> pass=0, err_count=1,
//    first_err_off=3, first_err_dst = first_err_src ^ 0x8000.
//  3 Wrap: src_start=0xFFE, dst_start=0xFFF, L=4 -> src addrs FFE,FFF,000,001;
//    dst addrs FFF,000,001,002; compares correct across wrap.
//  4 L=0 start -> result_valid=1 at cycle 1, pass=1, src_addr/dst_addr unchanged.
//  5 start pulsed again during READ -> ignored, run completes unchanged; start in
//    DONE -> result_valid drops next cycle, new run proceeds.
//  6 rst low at cycle 4 of L=8 run with mismatches -> all outputs 0 at once;
//    after release, IDLE, result_valid=0 until next start.

Source files
------------

// File: rtl/copy_verifier_if.sv
// Bus between the post-copy verifier and its environment: control, memory read ports, results.
// The verifier takes the master modport because it issues the read addresses.
interface copy_verifier_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WIDTH  = 16
);
  logic              start;
  logic [ADDR_W-1:0] src_start;
  logic [ADDR_W-1:0] dst_start;
  logic [ADDR_W-1:0] length;
  logic [ADDR_W-1:0] src_addr;
  logic [WIDTH-1:0]  src_dout;
  logic [ADDR_W-1:0] dst_addr;
  logic [WIDTH-1:0]  dst_dout;
  logic              busy;
  logic              result_valid;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_off;
  logic [WIDTH-1:0]  first_err_src;
  logic [WIDTH-1:0]  first_err_dst;

  modport master (
    input  start, src_start, dst_start, length, src_dout, dst_dout,
    output src_addr, dst_addr, busy, result_valid, pass, err_count,
           first_err_off, first_err_src, first_err_dst
  );

  modport slave (
    output start, src_start, dst_start, length, src_dout, dst_dout,
    input  src_addr, dst_addr, busy, result_valid, pass, err_count,
           first_err_off, first_err_src, first_err_dst
  );
endinterface

// File: rtl/copy_verifier.sv
// Post-copy checker: re-reads source and destination blocks through spare read ports,
// compares word pairs and reports pass/fail, mismatch count and the first failing word.
module copy_verifier #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WIDTH  = 16
) (
  input logic             clk,
  input logic             rst,
  copy_verifier_if.master bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] cmp_off_q, cmp_off_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_off_q, first_off_d;
  logic [WIDTH-1:0]  first_src_q, first_src_d;
  logic [WIDTH-1:0]  first_dst_q, first_dst_d;

  // State and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      rem_q       <= '0;
      cmp_off_q   <= '0;
      cmp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_off_q <= '0;
      first_src_q <= '0;
      first_dst_q <= '0;
    end else begin
      state_q     <= state_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      rem_q       <= rem_d;
      cmp_off_q   <= cmp_off_d;
      cmp_valid_q <= cmp_valid_d;
      busy_q      <= busy_d;
      rv_q        <= rv_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_off_q <= first_off_d;
      first_src_q <= first_src_d;
      first_dst_q <= first_dst_d;
    end
  end

  // Next-state, address sequencing and compare accumulation
  always_comb begin
    state_d     = state_q;
    src_addr_d  = src_addr_q;
    dst_addr_d  = dst_addr_q;
    rem_d       = rem_q;
    cmp_off_d   = cmp_off_q;
    cmp_valid_d = 1'b0;
    busy_d      = busy_q;
    rv_d        = rv_q;
    pass_d      = pass_q;
    err_d       = err_q;
    first_off_d = first_off_q;
    first_src_d = first_src_q;
    first_dst_d = first_dst_q;

    // Read data lags the address by one cycle, so compares run one cycle behind
    if (cmp_valid_q) begin
      if (bus.src_dout != bus.dst_dout) begin
        pass_d = 1'b0;
        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
        if (err_q == '0) begin
          first_off_d = cmp_off_q;
          first_src_d = bus.src_dout;
          first_dst_d = bus.dst_dout;
        end
      end
      cmp_off_d = cmp_off_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          rv_d        = 1'b0;
          pass_d      = 1'b1;
          err_d       = '0;
          first_off_d = '0;
          first_src_d = '0;
          first_dst_d = '0;
          cmp_off_d   = '0;
          if (bus.length == '0) begin
            state_d = DONE;
            rv_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d    = READ;
            busy_d     = 1'b1;
            src_addr_d = bus.src_start;
            dst_addr_d = bus.dst_start;
            rem_d      = bus.length - ADDR_W'(1);
          end
        end
      end
      READ: begin
        cmp_valid_d = 1'b1;
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else begin
          src_addr_d = src_addr_q + ADDR_W'(1);
          dst_addr_d = dst_addr_q + ADDR_W'(1);
          rem_d      = rem_q - ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        rv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.src_addr      = src_addr_q;
  assign bus.dst_addr      = dst_addr_q;
  assign bus.busy          = busy_q;
  assign bus.result_valid  = rv_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_off = first_off_q;
  assign bus.first_err_src = first_src_q;
  assign bus.first_err_dst = first_dst_q;
endmodule

// File: tb/tb_copy_verifier.sv
// Directed bench for copy_verifier: models both memories with one-cycle registered reads.
module tb_copy_verifier;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] src_mem [4096];
  logic [15:0] dst_mem [4096];

  copy_verifier_if #(.ADDR_W(12), .WIDTH(16)) bus ();

  copy_verifier #(.ADDR_W(12), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.src_dout <= src_mem[bus.src_addr];
    bus.dst_dout <= dst_mem[bus.dst_addr];
  end

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 297) ^ 23100);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic copy_blk(input logic [11:0] s, input logic [11:0] d, input int n);
    for (int k = 0; k < n; k++) dst_mem[12'(d + 12'(k))] = src_mem[12'(s + 12'(k))];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_src_addr"}, 32'(bus.src_addr), 32'd0);
    chk({tag, "_dst_addr"}, 32'(bus.dst_addr), 32'd0);
    chk({tag, "_off"}, 32'(bus.first_err_off), 32'd0);
    chk({tag, "_fsrc"}, 32'(bus.first_err_src), 32'd0);
    chk({tag, "_fdst"}, 32'(bus.first_err_dst), 32'd0);
  endtask

  // One full run; optional junk start pulse during READ at cycle pulse_at
  task automatic run(input string tag, input logic [11:0] s, input logic [11:0] d,
                     input logic [11:0] l, input int pulse_at, input logic exp_pass,
                     input logic [12:0] exp_err, input logic [11:0] exp_off,
                     input logic [15:0] exp_fs, input logic [15:0] exp_fd);
    @(negedge clk);
    bus.start = 1'b1; bus.src_start = s; bus.dst_start = d; bus.length = l;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_rv_clear"}, 32'(bus.result_valid), 32'd0);
    for (int k = 0; k < int'(l); k++) begin
      chk({tag, "_src_addr"}, 32'(bus.src_addr), 32'(12'(s + 12'(k))));
      chk({tag, "_dst_addr"}, 32'(bus.dst_addr), 32'(12'(d + 12'(k))));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (pulse_at == k + 1) begin
        bus.start = 1'b1; bus.src_start = 12'h100; bus.dst_start = 12'h200; bus.length = 12'd2;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk({tag, "_drain_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_drain_rv"}, 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_rv"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_pass"}, 32'(bus.pass), 32'(exp_pass));
    chk({tag, "_err"}, 32'(bus.err_count), 32'(exp_err));
    chk({tag, "_off"}, 32'(bus.first_err_off), 32'(exp_off));
    chk({tag, "_fsrc"}, 32'(bus.first_err_src), 32'(exp_fs));
    chk({tag, "_fdst"}, 32'(bus.first_err_dst), 32'(exp_fd));
    @(negedge clk);
    chk({tag, "_hold_rv"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_hold_err"}, 32'(bus.err_count), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      src_mem[i] = pat(i);
      dst_mem[i] = ~pat(i);
    end
    bus.start = 1'b0; bus.src_start = '0; bus.dst_start = '0; bus.length = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #5 chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Clean block
    copy_blk(12'h010, 12'h800, 8);
    run("clean", 12'h010, 12'h800, 12'd8, 0, 1'b1, 13'd0, 12'd0, 16'h0, 16'h0);

    // Single fault at offset 3, started from DONE
    dst_mem[12'h803] = dst_mem[12'h803] ^ 16'h8000;
    run("fault1", 12'h010, 12'h800, 12'd8, 0, 1'b0, 13'd1, 12'd3,
        pat(12'h013), pat(12'h013) ^ 16'h8000);

    // Second fault later: count grows, first capture held
    dst_mem[12'h806] = dst_mem[12'h806] ^ 16'h0001;
    run("fault2", 12'h010, 12'h800, 12'd8, 0, 1'b0, 13'd2, 12'd3,
        pat(12'h013), pat(12'h013) ^ 16'h8000);
    copy_blk(12'h010, 12'h800, 8);

    // Address wrap on both sides
    copy_blk(12'hFFE, 12'hFFF, 4);
    run("wrap", 12'hFFE, 12'hFFF, 12'd4, 0, 1'b1, 13'd0, 12'd0, 16'h0, 16'h0);

    // Zero length: straight to DONE, addresses untouched
    @(negedge clk);
    bus.start = 1'b1; bus.src_start = 12'h300; bus.dst_start = 12'h400; bus.length = 12'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_rv", 32'(bus.result_valid), 32'd1);
    chk("len0_pass", 32'(bus.pass), 32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    chk("len0_err", 32'(bus.err_count), 32'd0);
    chk("len0_src_addr", 32'(bus.src_addr), 32'h001);
    chk("len0_dst_addr", 32'(bus.dst_addr), 32'h002);

    // Start pulsed during READ is ignored
    run("ignore", 12'h010, 12'h800, 12'd8, 3, 1'b1, 13'd0, 12'd0, 16'h0, 16'h0);

    // Reset mid-run with mismatches at offsets 0 and 1
    dst_mem[12'h800] = dst_mem[12'h800] ^ 16'h0001;
    dst_mem[12'h801] = dst_mem[12'h801] ^ 16'h0100;
    @(negedge clk);
    bus.start = 1'b1; bus.src_start = 12'h010; bus.dst_start = 12'h800; bus.length = 12'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_err", 32'(bus.err_count), 32'd2);
    chk("abort_pre_pass", 32'(bus.pass), 32'd0);
    chk("abort_pre_addr", 32'(bus.src_addr), 32'h013);
    rst = 1'b0;
    #1 chk_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("post_abort");

    // Fresh run from IDLE after abort
    run("after_rst", 12'h010, 12'h800, 12'd2, 0, 1'b0, 13'd2, 12'd0,
        pat(12'h010), pat(12'h010) ^ 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
